arm7tdmi_perf_counter_bank: RTL and testbench

Programmable performance counter bank that replaces the fixed per-event cache/MMU counters. It counts any of `NUM_EVENTS` event lines on `NUM_COUNTERS` configurable counters, each with its own event select, edge or level mode, and saturate or wrap mode. It takes periodic atomic snapshots of all counters and can compute a hit-rate ratio from them in a sequential divider. It sits beside the cache, coherency and MMU blocks and is read by the debug/CP15 register path.

---
 rtl/arm7tdmi_perf_counter_bank.sv | 189 ++++++++++++++++++
 tb/tb_arm7tdmi_perf_counter_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_perf_counter_bank.sv
// rtl/arm7tdmi_perf_counter_bank.sv - programmable performance counter bank with snapshots and hit-rate divider
//
// Purpose: NUM_COUNTERS counters, each selecting one of NUM_EVENTS event lines,
// counting in level or rising-edge mode, saturating or wrapping, with sticky
// overflow flags. A sample timer (or snap_req) copies every counter into a
// snapshot bank in one cycle. With PERF_RATIO_EN defined, a restoring divider
// computes (snap[num] * 10000) / snap[den] one quotient bit per cycle. Without
// it the ratio outputs are tied to 0.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   event_in                      event lines from cache/coherency/MMU
//   global_en, clear_all          counting/timer enable, synchronous bank clear
//   sample_log2, snap_req         sample period 2^sample_log2, manual snapshot
//   cfg_we/idx/sel/edge/sat/cnt_en  per-counter configuration write
//   rd_idx, rd_live, rd_snap      combinational read of live and snapshot value
//   snap_valid, ovf_flags         snapshot update pulse, sticky overflow flags
//   ratio_start, ratio_num_idx, ratio_den_idx, ratio_busy, ratio_done, ratio_result
module arm7tdmi_perf_counter_bank #(
  parameter int NUM_EVENTS   = 32,
  parameter int NUM_COUNTERS = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_EVENTS-1:0]           event_in,
  input  logic                            global_en,
  input  logic                            clear_all,
  input  logic [4:0]                      sample_log2,
  input  logic                            snap_req,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_COUNTERS)-1:0] cfg_idx,
  input  logic [$clog2(NUM_EVENTS)-1:0]   cfg_sel,
  input  logic                            cfg_edge,
  input  logic                            cfg_sat,
  input  logic                            cfg_cnt_en,
  input  logic [$clog2(NUM_COUNTERS)-1:0] rd_idx,
  output logic [CNT_WIDTH-1:0]            rd_live,
  output logic [CNT_WIDTH-1:0]            rd_snap,
  output logic                            snap_valid,
  output logic [NUM_COUNTERS-1:0]         ovf_flags,
  input  logic                            ratio_start,
  input  logic [$clog2(NUM_COUNTERS)-1:0] ratio_num_idx,
  input  logic [$clog2(NUM_COUNTERS)-1:0] ratio_den_idx,
  output logic                            ratio_busy,
  output logic                            ratio_done,
  output logic [15:0]                     ratio_result
);
  localparam int IDX_W  = $clog2(NUM_COUNTERS);
  localparam int SEL_W  = $clog2(NUM_EVENTS);
  localparam int PROD_W = CNT_WIDTH + 14;

  logic [CNT_WIDTH-1:0]    cnt_q  [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0]    snap_q [NUM_COUNTERS];
  logic [SEL_W-1:0]        sel_q  [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] edge_q, sat_q, en_q, ovf_q, inc;
  logic [NUM_EVENTS-1:0]   ev_prev;
  logic [31:0]             timer_q, period_mask;
  logic                    tick, snap_trig, snap_valid_q;

  always_comb begin
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      inc[i] = global_en & en_q[i] & event_in[sel_q[i]] &
               (~edge_q[i] | ~ev_prev[sel_q[i]]);
    end
  end

  // >= rather than == so that shrinking sample_log2 mid-run resyncs at once
  // instead of waiting for the 32-bit timer to wrap.
  assign period_mask = (32'd1 << sample_log2) - 32'd1;
  assign tick        = global_en & (timer_q >= period_mask);
  assign snap_trig   = tick | snap_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
        sel_q[i]  <= '0;
      end
      edge_q       <= '0;
      sat_q        <= '0;
      en_q         <= '0;
      ovf_q        <= '0;
      ev_prev      <= '0;
      timer_q      <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      ev_prev      <= clear_all ? '0 : event_in;
      snap_valid_q <= snap_trig;
      if (clear_all)      timer_q <= '0;
      else if (global_en) timer_q <= tick ? 32'd0 : timer_q + 32'd1;

      if (cfg_we) begin
        sel_q[cfg_idx]  <= cfg_sel;
        edge_q[cfg_idx] <= cfg_edge;
        sat_q[cfg_idx]  <= cfg_sat;
        en_q[cfg_idx]   <= cfg_cnt_en;
      end

      for (int i = 0; i < NUM_COUNTERS; i++) begin
        // Snapshot sees the value before this cycle's increment.
        if (snap_trig) snap_q[i] <= cnt_q[i];
        if (clear_all || (cfg_we && cfg_idx == IDX_W'(i))) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (inc[i]) begin
          if (&cnt_q[i]) begin
            ovf_q[i] <= 1'b1;
            if (!sat_q[i]) cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign rd_live    = cnt_q[rd_idx];
  assign rd_snap    = snap_q[rd_idx];
  assign snap_valid = snap_valid_q;
  assign ovf_flags  = ovf_q;

`ifdef PERF_RATIO_EN
  localparam int STEP_W = $clog2(PROD_W + 1);

  logic                 busy_q, done_q, den_zero_q;
  logic [PROD_W-1:0]    dvd_q, quo_next;
  logic [CNT_WIDTH-1:0] den_q, rem_q;
  logic [CNT_WIDTH:0]   rem_shift;
  logic [STEP_W-1:0]    step_q;
  logic [15:0]          result_q;
  logic                 q_bit;

  // dvd_q shifts dividend bits out the top while quotient bits enter at the
  // bottom; after PROD_W steps it holds the full quotient.
  always_comb begin
    rem_shift = {rem_q, dvd_q[PROD_W-1]};
    q_bit     = rem_shift >= {1'b0, den_q};
    quo_next  = {dvd_q[PROD_W-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      den_zero_q <= 1'b0;
      dvd_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      step_q     <= '0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (ratio_start) begin
          busy_q     <= 1'b1;
          step_q     <= '0;
          rem_q      <= '0;
          dvd_q      <= PROD_W'(snap_q[ratio_num_idx]) * PROD_W'(10000);
          den_q      <= snap_q[ratio_den_idx];
          den_zero_q <= (snap_q[ratio_den_idx] == '0);
        end
      end else begin
        rem_q  <= q_bit ? CNT_WIDTH'(rem_shift - {1'b0, den_q}) : CNT_WIDTH'(rem_shift);
        dvd_q  <= quo_next;
        step_q <= step_q + STEP_W'(1);
        if (step_q == STEP_W'(PROD_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (den_zero_q)                 result_q <= '0;
          else if (|quo_next[PROD_W-1:16]) result_q <= 16'hFFFF;
          else                            result_q <= quo_next[15:0];
        end
      end
    end
  end

  assign ratio_busy   = busy_q;
  assign ratio_done   = done_q;
  assign ratio_result = result_q;
`else
  logic unused_ratio;
  assign unused_ratio = ^{ratio_start, ratio_num_idx, ratio_den_idx};
  assign ratio_busy   = 1'b0;
  assign ratio_done   = 1'b0;
  assign ratio_result = '0;
`endif
endmodule

// File: tb/tb_arm7tdmi_perf_counter_bank.sv
// tb/tb_arm7tdmi_perf_counter_bank.sv - directed bench for arm7tdmi_perf_counter_bank
module tb_arm7tdmi_perf_counter_bank;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] event_in;
  logic        global_en, clear_all, snap_req;
  logic [4:0]  sample_log2;
  logic        cfg_we, cfg_edge, cfg_sat, cfg_cnt_en;
  logic [2:0]  cfg_idx, rd_idx, ratio_num_idx, ratio_den_idx;
  logic [4:0]  cfg_sel;
  logic [W-1:0] rd_live, rd_snap;
  logic        snap_valid, ratio_start, ratio_busy, ratio_done;
  logic [7:0]  ovf_flags;
  logic [15:0] ratio_result;

  int total = 0;
  int bad   = 0;

  arm7tdmi_perf_counter_bank #(.NUM_EVENTS(32), .NUM_COUNTERS(8), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .global_en(global_en),
    .clear_all(clear_all), .sample_log2(sample_log2), .snap_req(snap_req),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_edge(cfg_edge),
    .cfg_sat(cfg_sat), .cfg_cnt_en(cfg_cnt_en), .rd_idx(rd_idx),
    .rd_live(rd_live), .rd_snap(rd_snap), .snap_valid(snap_valid),
    .ovf_flags(ovf_flags), .ratio_start(ratio_start),
    .ratio_num_idx(ratio_num_idx), .ratio_den_idx(ratio_den_idx),
    .ratio_busy(ratio_busy), .ratio_done(ratio_done), .ratio_result(ratio_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        edge_m;
    logic        ev;
    logic [15:0] exp_live;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [4:0] sel, input logic edg,
                     input logic sat, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_edge = edg; cfg_sat = sat; cfg_cnt_en = en;
    step();
    cfg_we = 1'b0;
  endtask

`ifdef PERF_RATIO_EN
  // start in cycle N; done expected in N + W + 15
  task automatic run_ratio(input string name, input logic [2:0] n, input logic [2:0] d,
                           input logic [15:0] exp_res, input int poke_at);
    int lat = 0;
    ratio_num_idx = n; ratio_den_idx = d; ratio_start = 1'b1;
    step();
    ratio_start = 1'b0;
    chk({name, "_busy"}, ratio_busy, 1);
    for (int k = 2; k <= 60 && lat == 0; k++) begin
      if (k == poke_at) begin
        ratio_num_idx = 3'd4; ratio_den_idx = 3'd6; ratio_start = 1'b1;
      end
      step();
      ratio_start = 1'b0;
      if (ratio_done) lat = k;
    end
    chk({name, "_latency"}, lat, W + 15);
    chk({name, "_result"}, ratio_result, exp_res);
    chk({name, "_busy_off"}, ratio_busy, 0);
  endtask
`endif

  initial begin
    int dones;
    rst = 1'b1; event_in = '0; global_en = 1'b0; clear_all = 1'b0; snap_req = 1'b0;
    sample_log2 = 5'd31; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_edge = 1'b0;
    cfg_sat = 1'b0; cfg_cnt_en = 1'b0; rd_idx = '0; ratio_start = 1'b0;
    ratio_num_idx = '0; ratio_den_idx = '0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'd4};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'd5};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'd5};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 16'd3};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 16'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'd1};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_live", rd_live, 0);
    chk("reset_snap", rd_snap, 0);
    chk("reset_snap_valid", snap_valid, 0);
    chk("reset_ovf", ovf_flags, 0);
    chk("reset_ratio", {ratio_busy, ratio_done, ratio_result}, 0);

    // level, edge and cfg-vs-event priority on counter 0, event line 3
    global_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cfg_we = vecs[i].we; cfg_idx = 3'd0; cfg_sel = 5'd3; cfg_edge = vecs[i].edge_m;
      cfg_sat = 1'b0; cfg_cnt_en = 1'b1;
      event_in = {28'd0, vecs[i].ev, 3'd0};
      step();
      chk($sformatf("vec%0d_live", i), rd_live, vecs[i].exp_live);
    end
    cfg_we = 1'b0; event_in = '0;

    // counter 0 saturates, counter 1 wraps, both from 0xFFFE
    cfg(3'd0, 5'd3, 1'b0, 1'b1, 1'b1);
    cfg(3'd1, 5'd3, 1'b0, 1'b0, 1'b1);
    event_in = 32'd1 << 3;
    repeat (65534) step();
    event_in = '0;
    rd_idx = 3'd0; #1 chk("pre_sat_live0", rd_live, 16'hFFFE);
    rd_idx = 3'd1; #1 chk("pre_wrap_live1", rd_live, 16'hFFFE);
    event_in = 32'd1 << 3;
    step();
    chk("allones_no_ovf", ovf_flags, 8'h00);
    step();
    chk("ovf_both", ovf_flags, 8'h03);
    step();
    event_in = '0;
    rd_idx = 3'd0; #1 chk("sat_live0", rd_live, 16'hFFFF);
    rd_idx = 3'd1; #1 chk("wrap_live1", rd_live, 16'h0001);
    chk("ovf_sticky", ovf_flags, 8'h03);

    // clear_all beats simultaneous events on every counter
    for (int i = 2; i < 8; i++) cfg(3'(i), 5'(i), 1'b0, 1'b0, 1'b1);
    event_in = '1;
    step(); step();
    rd_idx = 3'd7; #1 chk("pre_clear_live7", rd_live, 2);
    clear_all = 1'b1;
    step();
    clear_all = 1'b0; event_in = '0;
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i); #1 chk($sformatf("clear_live%0d", i), rd_live, 0);
    end
    chk("clear_ovf", ovf_flags, 0);

    // sample timer, period 8; counter 2 counts every cycle from the clear
    event_in = 32'd1 << 2; sample_log2 = 5'd3; clear_all = 1'b1; rd_idx = 3'd2;
    step();
    clear_all = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      step();
      chk($sformatf("tick_valid_c%0d", k), snap_valid, (k == 9 || k == 17) ? 1 : 0);
      if (k == 9) begin
        chk("tick_snap1", rd_snap, 7);
        chk("tick_live1", rd_live, 8);
      end
      if (k == 17) chk("tick_snap2", rd_snap, 15);
    end
    sample_log2 = 5'd31; event_in = '0;

    // ratio operands: cnt3=750, cnt4=1000, cnt5=0 (disabled), cnt6=1
    cfg(3'd3, 5'd6, 1'b0, 1'b0, 1'b1);
    cfg(3'd4, 5'd7, 1'b0, 1'b0, 1'b1);
    cfg(3'd5, 5'd9, 1'b0, 1'b0, 1'b0);
    cfg(3'd6, 5'd8, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 1000; k++) begin
      event_in = (32'd1 << 7) | (k < 750 ? 32'd1 << 6 : 32'd0) |
                 (k == 0 ? 32'd1 << 8 : 32'd0) | (32'd1 << 9);
      step();
    end
    event_in = '0; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("manual_snap_valid", snap_valid, 1);
    rd_idx = 3'd3; #1 chk("snap_num", rd_snap, 750);
    rd_idx = 3'd4; #1 chk("snap_den", rd_snap, 1000);
    rd_idx = 3'd6; #1 chk("snap_one", rd_snap, 1);

`ifdef PERF_RATIO_EN
    run_ratio("ratio_750_1000", 3'd3, 3'd4, 16'd7500, 0);
    repeat (3) step();
    chk("ratio_hold", ratio_result, 7500);
    run_ratio("ratio_den0", 3'd3, 3'd5, 16'd0, 0);
    run_ratio("ratio_sat", 3'd4, 3'd6, 16'hFFFF, 0);
    run_ratio("ratio_start_busy", 3'd3, 3'd4, 16'd7500, 5);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ratio_done) dones++;
    end
    chk("busy_start_ignored", dones, 0);
    ratio_num_idx = 3'd3; ratio_den_idx = 3'd4; ratio_start = 1'b1;
    step();
    ratio_start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1 chk("rst_drops_busy", ratio_busy, 0);
    step();
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ratio_done) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_result", ratio_result, 0);
`else
    ratio_num_idx = 3'd3; ratio_den_idx = 3'd4; ratio_start = 1'b1;
    step();
    ratio_start = 1'b0;
    chk("noratio_busy", ratio_busy, 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (ratio_done || ratio_busy) dones++;
    end
    chk("noratio_done", dones, 0);
    chk("noratio_result", ratio_result, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
